// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command encodings, init sequencer states and timing helpers
package sdram_pkg;
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LMR          = 4'b0000;
  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_TRP, ST_AR, ST_TRFC, ST_LMR, ST_TMRD, ST_DONE
  } init_state_e;
  function automatic int ns_to_clk(input int t_ns, input int period_ns);
    int n;
    n = (t_ns + period_ns - 1) / period_ns;
    return n < 1 ? 1 : n;
  endfunction
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sdram_wait_timer.sv
// sdram_wait_timer: clear/enable cycle counter with terminal-count compare
module sdram_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc = cnt_q == lim;
  always_comb cnt_d = en && !tc ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sdram_init_cfg.sv
// sdram_init_cfg: parametrised SDRAM power-up/init sequencer with re-init and
// run-time mode-register reload (req/ack)
module sdram_init_cfg
  import sdram_pkg::*;
#(
  parameter int             CLK_PERIOD_NS  = 10,
  parameter int             T_POWERUP_NS   = 100000,
  parameter int             T_RP_NS        = 20,
  parameter int             T_RFC_NS       = 66,
  parameter int             T_MRD_CLK      = 2,
  parameter int             INIT_AR_NUM    = 2,
  parameter int             ADDR_W         = 13,
  parameter int             BA_W           = 2,
  parameter int             CAS_LAT        = 3,
  parameter logic [2:0]     BURST_LEN_CODE = 3'b111,
  parameter int             BURST_TYPE     = 0,
  parameter int             WRITE_BURST    = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              reinit_req,
  input  logic              lmr_req,
  input  logic [ADDR_W-1:0] lmr_mode,
  output logic              lmr_ack,
  output logic [3:0]        init_cmd,
  output logic [BA_W-1:0]   init_ba,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_end,
  output logic              busy
);
  localparam int N_PWR = ns_to_clk(T_POWERUP_NS, CLK_PERIOD_NS);
  localparam int N_RP  = ns_to_clk(T_RP_NS, CLK_PERIOD_NS);
  localparam int N_RFC = ns_to_clk(T_RFC_NS, CLK_PERIOD_NS);
  localparam int N_MRD = T_MRD_CLK < 1 ? 1 : T_MRD_CLK;
  localparam int W     = $clog2(max_int(max_int(N_PWR, N_RP), max_int(N_RFC, N_MRD)) + 1);
  localparam logic [ADDR_W-1:0] MODE_DEF = {{(ADDR_W-10){1'b0}}, 1'(WRITE_BURST), 2'b00,
                                            3'(CAS_LAT), 1'(BURST_TYPE), BURST_LEN_CODE};
  init_state_e       state_q, state_d;
  logic [3:0]        ar_q, ar_d;
  logic              reload_q, reload_d;
  logic [ADDR_W-1:0] mode_q, mode_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              end_q, end_d, busy_q, busy_d, ack_q, ack_d;
  logic              wait_en, wait_tc;
  logic [W-1:0]      wait_lim;
  sdram_wait_timer #(.W(W)) u_wait (
    .clk(sys_clk), .rst_n(sys_rst_n), .en(wait_en), .lim(wait_lim), .tc(wait_tc)
  );
  assign {lmr_ack, init_cmd, init_ba, init_addr, init_end, busy} =
         {ack_q, cmd_q, ba_q, addr_q, end_q, busy_q};
  always_comb begin
    wait_en  = state_q inside {ST_IDLE, ST_TRP, ST_TRFC, ST_TMRD};
    wait_lim = state_q == ST_IDLE ? W'(N_PWR - 1) :
               state_q == ST_TRP  ? W'(N_RP - 1)  :
               state_q == ST_TRFC ? W'(N_RFC - 1) : W'(N_MRD - 1);
    state_d  = state_q;
    ar_d     = ar_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    ack_d    = 1'b0;
    case (state_q)
      ST_IDLE: if (wait_tc) state_d = ST_PRE;
      ST_PRE:  state_d = ST_TRP;
      ST_TRP:  if (wait_tc) state_d = reload_q ? ST_LMR : ST_AR;
      ST_AR: begin
        state_d = ST_TRFC;
        ar_d    = ar_q + 4'd1;
      end
      ST_TRFC: if (wait_tc) state_d = ar_q < 4'(INIT_AR_NUM) ? ST_AR : ST_LMR;
      ST_LMR:  state_d = ST_TMRD;
      ST_TMRD: if (wait_tc) state_d = ST_DONE;
      default: begin
        // a finished reload is acknowledged on the first DONE cycle; its
        // pending flag also blocks re-accepting the still-held lmr_req
        ack_d    = reload_q;
        reload_d = 1'b0;
        if (reinit_req) begin
          state_d = ST_PRE;
          ar_d    = '0;
          mode_d  = MODE_DEF;
        end else if (lmr_req && !reload_q) begin
          state_d  = ST_PRE;
          reload_d = 1'b1;
          mode_d   = lmr_mode;
        end
      end
    endcase
    cmd_d  = state_q == ST_PRE ? CMD_PRECHARGE :
             state_q == ST_AR  ? CMD_AUTO_REFRESH :
             state_q == ST_LMR ? CMD_LMR : CMD_NOP;
    ba_d   = state_q == ST_LMR ? '0 : '1;
    addr_d = state_q == ST_LMR ? mode_q : '1;
    end_d  = state_q == ST_DONE;
    busy_d = state_q != ST_DONE;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      ar_q     <= '0;
      reload_q <= 1'b0;
      mode_q   <= MODE_DEF;
      cmd_q    <= CMD_NOP;
      ba_q     <= '1;
      addr_q   <= '1;
      end_q    <= 1'b0;
      busy_q   <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ar_q     <= ar_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      cmd_q    <= cmd_d;
      ba_q     <= ba_d;
      addr_q   <= addr_d;
      end_q    <= end_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
    end
endmodule

// File: tb/tb_sdram_init_cfg.sv
// tb_sdram_init_cfg: randomized scenarios on two configurations, checked
// cycle-by-cycle against a command-timeline model of the sequencer
module tb_sdram_init_cfg;
  localparam int A_PWR = 10000, A_RP = 2, A_RFC = 7, A_MRD = 2, A_AR = 2;
  localparam int B_PWR = 100, B_RP = 3, B_RFC = 10, B_MRD = 2, B_AR = 8;
  localparam logic [12:0] DEF_MODE = 13'h037;
  localparam logic [21:0] RST_VAL = {4'b0111, 2'b11, 13'h1fff, 1'b0, 1'b1, 1'b0};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a_n, rst_b_n, reinit_a, reinit_b, lmr_req_a, lmr_req_b;
  logic ack_a, ack_b, end_a, end_b, busy_a, busy_b;
  logic [12:0] mode_a, mode_b, addr_a, addr_b;
  logic [3:0] cmd_a, cmd_b;
  logic [1:0] ba_a, ba_b;
  logic [21:0] got_a, got_b;
  int checks = 0, passed = 0;
  assign got_a = {cmd_a, ba_a, addr_a, end_a, busy_a, ack_a};
  assign got_b = {cmd_b, ba_b, addr_b, end_b, busy_b, ack_b};
  sdram_init_cfg dut_a (
    .sys_clk(clk), .sys_rst_n(rst_a_n), .reinit_req(reinit_a), .lmr_req(lmr_req_a),
    .lmr_mode(mode_a), .lmr_ack(ack_a), .init_cmd(cmd_a), .init_ba(ba_a),
    .init_addr(addr_a), .init_end(end_a), .busy(busy_a)
  );
  sdram_init_cfg #(.CLK_PERIOD_NS(7), .T_POWERUP_NS(700), .INIT_AR_NUM(8)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_b_n), .reinit_req(reinit_b), .lmr_req(lmr_req_b),
    .lmr_mode(mode_b), .lmr_ack(ack_b), .init_cmd(cmd_b), .init_ba(ba_b),
    .init_addr(addr_b), .init_end(end_b), .busy(busy_b)
  );
  // cycle (relative to the PRECHARGE output) at which init_end rises
  function automatic int t_end(bit rl, int ar, int rp, int rfc, int mrd);
    return (rl ? rp + 1 : rp + 1 + ar * (rfc + 1)) + mrd + 1;
  endfunction
  // expected {cmd, ba, addr, init_end, busy, lmr_ack} at relative cycle r
  function automatic logic [21:0] model(bit rl, int ar, int rp, int rfc, int mrd,
                                        logic [12:0] mw, int r);
    int tl = rl ? rp + 1 : rp + 1 + ar * (rfc + 1);
    int te = tl + mrd + 1;
    logic [3:0] c = 4'b0111;
    logic [1:0] b = 2'b11;
    logic [12:0] a = 13'h1fff;
    bit e = r >= te;
    if (r == 0) c = 4'b0010;
    if (!rl && r > rp && r < tl && (r - rp - 1) % (rfc + 1) == 0) c = 4'b0001;
    if (r == tl) begin
      c = 4'b0000;
      b = 2'b00;
      a = mw;
    end
    return {c, b, a, e, !e, rl && r == te};
  endfunction
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (got_a !== RST_VAL) $display("FAIL reset_a got %h exp %h", got_a, RST_VAL); else passed++;
    checks++;
    if (got_b !== RST_VAL) $display("FAIL reset_b got %h exp %h", got_b, RST_VAL); else passed++;
  endtask
  task automatic test_init_b();
    int k;
    logic [21:0] e;
    rst_b_n = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (cmd_b === 4'b0111 && k < B_PWR + 50);
    checks++;
    if (k != B_PWR + 1) $display("FAIL powerup_b cycles got %0d exp %0d", k, B_PWR + 1); else passed++;
    for (int r = 0; r <= t_end(0, B_AR, B_RP, B_RFC, B_MRD) + 1; r++) begin
      e = model(0, B_AR, B_RP, B_RFC, B_MRD, DEF_MODE, r);
      checks++;
      if (got_b !== e) $display("FAIL init_b r=%0d got %h exp %h", r, got_b, e); else passed++;
      @(negedge clk);
    end
  endtask
  task automatic test_init_a();
    int k;
    logic [21:0] e;
    rst_a_n = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (cmd_a === 4'b0111 && k < A_PWR + 50);
    checks++;
    if (k != A_PWR + 1) $display("FAIL powerup_a cycles got %0d exp %0d", k, A_PWR + 1); else passed++;
    for (int r = 0; r <= t_end(0, A_AR, A_RP, A_RFC, A_MRD) + 1; r++) begin
      e = model(0, A_AR, A_RP, A_RFC, A_MRD, DEF_MODE, r);
      checks++;
      if (got_a !== e) $display("FAIL init_a r=%0d got %h exp %h", r, got_a, e); else passed++;
      @(negedge clk);
    end
  endtask
  task automatic test_reload_a();
    logic [21:0] e;
    mode_a = 13'h022;
    lmr_req_a = 1'b1;
    repeat (2) @(negedge clk);
    mode_a = 13'h1abc;
    for (int r = 0; r <= t_end(1, A_AR, A_RP, A_RFC, A_MRD) + 1; r++) begin
      e = model(1, A_AR, A_RP, A_RFC, A_MRD, 13'h022, r);
      checks++;
      if (got_a !== e) $display("FAIL reload_a r=%0d got %h exp %h", r, got_a, e); else passed++;
      if (ack_a) lmr_req_a = 1'b0;
      @(negedge clk);
    end
    lmr_req_a = 1'b0;
  endtask
  task automatic test_reload_b();
    logic [21:0] e;
    logic [12:0] m;
    repeat (4) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      m = 13'($urandom);
      mode_b = m;
      lmr_req_b = 1'b1;
      repeat (2) @(negedge clk);
      mode_b = 13'($urandom);
      for (int r = 0; r <= t_end(1, B_AR, B_RP, B_RFC, B_MRD) + 1; r++) begin
        e = model(1, B_AR, B_RP, B_RFC, B_MRD, m, r);
        checks++;
        if (got_b !== e) $display("FAIL reload_b r=%0d got %h exp %h", r, got_b, e); else passed++;
        if (ack_b) lmr_req_b = 1'b0;
        @(negedge clk);
      end
      lmr_req_b = 1'b0;
    end
  endtask
  task automatic test_simul_a();
    logic [21:0] e;
    logic [12:0] m;
    m = 13'($urandom);
    mode_a = m;
    reinit_a = 1'b1;
    lmr_req_a = 1'b1;
    @(negedge clk);
    reinit_a = 1'b0;
    @(negedge clk);
    for (int r = 0; r <= t_end(0, A_AR, A_RP, A_RFC, A_MRD); r++) begin
      e = model(0, A_AR, A_RP, A_RFC, A_MRD, DEF_MODE, r);
      checks++;
      if (got_a !== e) $display("FAIL simul_reinit r=%0d got %h exp %h", r, got_a, e); else passed++;
      @(negedge clk);
    end
    for (int r = 0; r <= t_end(1, A_AR, A_RP, A_RFC, A_MRD) + 1; r++) begin
      e = model(1, A_AR, A_RP, A_RFC, A_MRD, m, r);
      checks++;
      if (got_a !== e) $display("FAIL simul_reload r=%0d got %h exp %h", r, got_a, e); else passed++;
      if (ack_a) lmr_req_a = 1'b0;
      @(negedge clk);
    end
    lmr_req_a = 1'b0;
  endtask
  task automatic test_reinit_ignored_b();
    logic [21:0] e;
    int rp;
    repeat (3) begin
      rp = B_RP + 1 + int'($urandom_range(0, B_AR - 1)) * (B_RFC + 1)
           + int'($urandom_range(0, B_RFC - 1));
      reinit_b = 1'b1;
      @(negedge clk);
      reinit_b = 1'b0;
      @(negedge clk);
      for (int r = 0; r <= t_end(0, B_AR, B_RP, B_RFC, B_MRD) + 1; r++) begin
        e = model(0, B_AR, B_RP, B_RFC, B_MRD, DEF_MODE, r);
        checks++;
        if (got_b !== e) $display("FAIL reinit_ign_b r=%0d got %h exp %h", r, got_b, e); else passed++;
        reinit_b = r == rp;
        @(negedge clk);
      end
    end
  endtask
  task automatic test_reset_mid_a();
    logic [21:0] e;
    int rp, k;
    rp = A_RP + 1 + int'($urandom_range(0, A_AR - 1)) * (A_RFC + 1)
         + int'($urandom_range(0, A_RFC - 1));
    reinit_a = 1'b1;
    @(negedge clk);
    reinit_a = 1'b0;
    @(negedge clk);
    for (int r = 0; r <= rp; r++) begin
      e = model(0, A_AR, A_RP, A_RFC, A_MRD, DEF_MODE, r);
      checks++;
      if (got_a !== e) $display("FAIL pre_rst_a r=%0d got %h exp %h", r, got_a, e); else passed++;
      if (r < rp) @(negedge clk);
    end
    rst_a_n = 1'b0;
    #1;
    checks++;
    if (got_a !== RST_VAL) $display("FAIL async_rst_a got %h exp %h", got_a, RST_VAL); else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (got_a !== RST_VAL) $display("FAIL held_rst_a got %h exp %h", got_a, RST_VAL); else passed++;
    rst_a_n = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (cmd_a === 4'b0111 && k < A_PWR + 50);
    checks++;
    if (k != A_PWR + 1) $display("FAIL repowerup_a cycles got %0d exp %0d", k, A_PWR + 1); else passed++;
  endtask
  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    reinit_a = 1'b0;
    reinit_b = 1'b0;
    lmr_req_a = 1'b0;
    lmr_req_b = 1'b0;
    mode_a = '0;
    mode_b = '0;
    test_reset();
    test_init_b();
    test_init_a();
    test_reload_a();
    test_reload_b();
    test_simul_a();
    test_reinit_ignored_b();
    test_reset_mid_a();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
